// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit types, limits and validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    function automatic logic bcd_digit_valid(input bcd_digit_t d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD down-counting digit with load and borrow chain link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       dec_in,
    output bcd_digit_t digit,
    output logic       borrow_out
);

    bcd_digit_t r_digit;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
        end else if (ld) begin
            r_digit <= ld_val;
        end else if (dec_in) begin
            r_digit <= (r_digit == '0) ? DIGIT_MAX : (r_digit - 4'd1);
        end
    end

    assign digit      = r_digit;
    assign borrow_out = (r_digit == '0) && dec_in;

endmodule : bcd_down_digit

`default_nettype wire

// File: rtl/bcd_down_timer.sv
// ============================================================================
// Module      : bcd_down_timer
// Description : Multi-digit BCD down timer with load validation and done pulse.
//               Optional auto-reload: define BCD_TIMER_AUTO_RELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      tick,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      running,
    output logic                      zero,
    output logic                      done,
    output logic                      load_err
);

    localparam int c_W = DIGIT_W * DIGITS;
    localparam logic [c_W-1:0] c_ONE = c_W'(1);

    timer_state_t     r_state;
    logic             r_done;
    logic             r_load_err;

    logic [DIGITS-1:0] w_digit_ok;
    logic [DIGITS:0]   w_chain;
    logic              w_load_ok;
    logic              w_dec;
    logic              w_expire;
    logic              w_reload_hit;
    logic              w_ld;
    logic [c_W-1:0]    w_ld_val;

    assign w_load_ok = load && (&w_digit_ok);
    assign w_dec     = (r_state == ST_RUN) && tick && !load && !stop;
    assign w_expire  = w_dec && (count == c_ONE);
    assign w_chain[0] = w_dec;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [c_W-1:0] r_reload;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_reload <= '0;
        end else if (w_load_ok) begin
            r_reload <= load_val;
        end
    end

    // A zero reload value falls back to the plain stop-at-zero expiry.
    assign w_reload_hit = w_expire && (r_reload != '0);
    assign w_ld         = w_load_ok || w_reload_hit;
    assign w_ld_val     = w_load_ok ? load_val : r_reload;
`else
    assign w_reload_hit = 1'b0;
    assign w_ld         = w_load_ok;
    assign w_ld_val     = load_val;
`endif

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_digit_ok[i] = bcd_digit_valid(load_val[i*DIGIT_W +: DIGIT_W]);

            bcd_down_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .ld         (w_ld),
                .ld_val     (w_ld_val[i*DIGIT_W +: DIGIT_W]),
                .dec_in     (w_chain[i]),
                .digit      (count[i*DIGIT_W +: DIGIT_W]),
                .borrow_out (w_chain[i+1])
            );
        end
    endgenerate

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= w_expire;
            r_load_err <= load && !(&w_digit_ok);
            if (load) begin
                if (w_load_ok) begin
                    r_state <= ST_IDLE;
                end
            end else if (stop) begin
                r_state <= ST_IDLE;
            end else if (start && (r_state == ST_IDLE) && !zero) begin
                r_state <= ST_RUN;
            end else if ((w_expire && !w_reload_hit) || w_chain[DIGITS]) begin
                // A borrow out of the top digit cannot occur while running is
                // only armed on a non-zero count; it disarms defensively.
                r_state <= ST_IDLE;
            end
        end
    end

    assign running  = (r_state == ST_RUN);
    assign done     = r_done;
    assign load_err = r_load_err;
    assign zero     = (count == '0);

endmodule : bcd_down_timer

`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
// ============================================================================
// Module      : tb_bcd_down_timer
// Description : Directed self-checking bench for bcd_down_timer (4 digits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_down_timer;

    localparam int DIGITS = 4;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b1;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        stop;
    logic        tick;
    logic [15:0] count;
    logic        running;
    logic        zero;
    logic        done;
    logic        load_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .count    (count),
        .running  (running),
        .zero     (zero),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, then settle just past the falling edge.
    task automatic step(input logic l, input logic [15:0] v, input logic sa,
                        input logic so, input logic t);
        load     = l;
        load_val = v;
        start    = sa;
        stop     = so;
        tick     = t;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        #12;
        chk("rst_count", count, 16'h0000);
        chk("rst_running", running, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_load_err", load_err, 1'b0);
        chk("rst_zero", zero, 1'b1);
        rst = 1'b0;

        step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("load3_count", count, 16'h0003);
        chk("load3_running", running, 1'b0);
        chk("load3_zero", zero, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("idle_tick_hold", count, 16'h0003);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("start_running", running, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("tick1_count", count, 16'h0002);
        chk("tick1_done", done, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("tick2_count", count, 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("expire_count", count, AUTO ? 16'h0003 : 16'h0000);
        chk("expire_done", done, 1'b1);
        chk("expire_running", running, AUTO);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("done_one_period", done, 1'b0);

        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("load0_running", running, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("start_at_zero_running", running, 1'b0);
        chk("start_at_zero_done", done, 1'b0);
        chk("start_at_zero_err", load_err, 1'b0);

        step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("borrow_count", count, 16'h0999);
        chk("borrow_done", done, 1'b0);
        chk("borrow_running", running, 1'b1);

        step(1'b1, 16'h12A4, 1'b0, 1'b0, 1'b1);
        chk("bad_load_err", load_err, 1'b1);
        chk("bad_load_count", count, 16'h0999);
        chk("bad_load_running", running, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("bad_load_err_clear", load_err, 1'b0);
        chk("bad_load_count_hold", count, 16'h0999);

        step(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
        chk("load9999_count", count, 16'h9999);
        chk("load9999_abort", running, 1'b0);
        chk("load9999_err", load_err, 1'b0);
        chk("load9999_done", done, 1'b0);

        step(1'b1, 16'h0050, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("run50_running", running, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk("stop_wins", running, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("stopped_tick_count", count, 16'h0050);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("start_while_run_count", count, 16'h0049);
        chk("start_while_run_running", running, 1'b1);

        step(1'b1, 16'h0420, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("run420_running", running, 1'b1);
        load = 1'b0; start = 1'b0; tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", count, 16'h0000);
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_done", done, 1'b0);
        #2 rst = 1'b0;
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        chk("post_rst_idle_running", running, 1'b0);
        chk("post_rst_idle_count", count, 16'h0000);
        chk("post_rst_idle_done", done, 1'b0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ar_t1_count", count, 16'h0001);
        chk("ar_t1_done", done, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ar_t2_count", count, 16'h0002);
        chk("ar_t2_done", done, 1'b1);
        chk("ar_t2_running", running, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ar_t3_count", count, 16'h0001);
        chk("ar_t3_done", done, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("ar_t4_count", count, 16'h0002);
        chk("ar_t4_done", done, 1'b1);
        chk("ar_t4_running", running, 1'b1);
`endif

        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_bcd_down_timer

`default_nettype wire

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter DIGITS, default 4, is the number of BCD digits in the counter (legal range 1..8).
REQ-002 clk  input  1  clock; all state updates occur on the falling edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 load  input  1  load request; load_val is sampled on the same edge.
REQ-005 load_val  input  4*DIGITS  preset value, packed BCD; digit 0 is in bits [3:0].
REQ-006 start  input  1  arms counting.
REQ-007 stop  input  1  pauses counting.
REQ-008 tick  input  1  decrement strobe (prescaler output); it is ignored unless the timer is running.
REQ-009 count  output  4*DIGITS  current packed BCD value; registered.
REQ-010 running  output  1  timer is armed; registered.
REQ-011 zero  output  1  count equals all-zero digits; combinational from count.
REQ-012 done  output  1  one-period pulse when a count expires; registered.
REQ-013 load_err  output  1  one-period pulse when a load is rejected; registered.

Function
REQ-014 Per edge, the priority order SHALL be: load, stop, start, tick.
REQ-015 A load with every load_val digit <= 9 SHALL set count to load_val and clear running.
REQ-016 A load with any digit > 9 SHALL leave count and running unchanged and pulse load_err for one period.
REQ-017 stop=1 without load SHALL clear running; if start and stop are high on the same edge, stop wins.
REQ-018 start=1 with count != 0 SHALL set running; start with count == 0 SHALL be ignored, with no done and no error.
REQ-019 A decrement occurs on an edge with running=1, tick=1, and no load or stop.
REQ-020 Decrement: digit 0 decrements by 1. A digit at 0 that receives a borrow wraps to 9 and passes the borrow to the next digit (example: 1000 -> 0999).
REQ-021 A decrement from a count of 0...01 SHALL set count to 0, clear running, and assert done on the same edge for exactly one period.
REQ-022 tick while running=0 SHALL have no effect; count holds.
REQ-023 A start issued while already running SHALL be a no-op.
REQ-024 load while running SHALL abort: running clears and done is not asserted.
REQ-025 count SHALL never hold a digit > 9.

Reset
REQ-026 While rst=1: count=0, running=0, done=0, load_err=0, and the reload register (if present) is 0.
REQ-027 rst asserted mid-count SHALL take effect immediately without waiting for a clock edge; no done pulse is generated.
REQ-028 After rst deasserts, the block idles until the first valid load.

Configuration
REQ-029 Macro BCD_TIMER_AUTO_RELOAD_EN, when defined, SHALL add a reload register that captures every accepted load_val.
REQ-030 With the macro defined, the expiring decrement SHALL set count to the reload value, pulse done, and keep running=1. If the reload value is 0, behaviour follows REQ-021.
REQ-031 With the macro undefined, there is no reload register, and expiry behaves exactly as REQ-021.

Structure
REQ-032 Shared package bcd_pkg SHALL hold: DIGIT_W=4, DIGIT_MAX=4'd9, typedef bcd_digit_t, and a function that checks whether a digit is valid BCD.
REQ-033 Sub-module bcd_down_digit SHALL cover one digit: inputs clk, rst, ld, ld_val, dec_in; outputs digit and a combinational borrow_out (digit==0 and dec_in).
REQ-034 The top level SHALL instantiate DIGITS copies of bcd_down_digit in a borrow chain, plus the control logic and load validation.

Verification
REQ-035 Load 0003, start, then 3 ticks -> count 0002, 0001, 0000; done high for 1 period on the third tick; running 0.
REQ-036 Load 1000, start, 1 tick -> count 0999; done stays 0.
REQ-037 Load 12A4 -> load_err pulses once; count and running are unchanged.
REQ-038 While running at 0050, assert start and stop together on one edge -> running 0; the next tick leaves count at 0050.
REQ-039 Running at 0420, assert rst between edges -> count 0000 and running 0 immediately; done stays 0.
REQ-040 With BCD_TIMER_AUTO_RELOAD_EN defined: load 0002, start, 4 ticks -> counts 0001, 0002, 0001, 0002; done pulses on ticks 2 and 4; running stays 1.
